// File: rtl/div_share_arbiter_if.sv
// Signal bundle for div_share_arbiter: two requester operand ports, the shared divider's
// control/status lines and the tagged response bus.
interface div_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             Req0_valid;
    logic [WIDTH-1:0] Req0_dividend;
    logic [WIDTH-1:0] Req0_divisor;
    logic             Req0_ready;

    logic             Req1_valid;
    logic [WIDTH-1:0] Req1_dividend;
    logic [WIDTH-1:0] Req1_divisor;
    logic             Req1_ready;

    logic             Div_start;
    logic [WIDTH-1:0] Div_dividend;
    logic [WIDTH-1:0] Div_divisor;
    logic             Div_done;
    logic [WIDTH-1:0] Div_quotient;
    logic [WIDTH-1:0] Div_remainder;

    logic             Rsp_valid;
    logic             Rsp_id;
    logic [WIDTH-1:0] Rsp_quotient;
    logic [WIDTH-1:0] Rsp_remainder;
    logic             Rsp_divzero;
    logic             Rsp_timeout;

    modport slave (
        input  Req0_valid, Req0_dividend, Req0_divisor,
        output Req0_ready,
        input  Req1_valid, Req1_dividend, Req1_divisor,
        output Req1_ready,
        output Div_start, Div_dividend, Div_divisor,
        input  Div_done, Div_quotient, Div_remainder,
        output Rsp_valid, Rsp_id, Rsp_quotient, Rsp_remainder, Rsp_divzero, Rsp_timeout
    );

    modport master (
        output Req0_valid, Req0_dividend, Req0_divisor,
        input  Req0_ready,
        output Req1_valid, Req1_dividend, Req1_divisor,
        input  Req1_ready,
        input  Div_start, Div_dividend, Div_divisor,
        output Div_done, Div_quotient, Div_remainder,
        input  Rsp_valid, Rsp_id, Rsp_quotient, Rsp_remainder, Rsp_divzero, Rsp_timeout
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one restoring divider between two requesters, with local divide-by-zero.
// Optional watchdog on the divider handshake is enabled by defining DIV_TIMEOUT_EN.
module div_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic               Clock,
    input  logic               Resetn,
    div_share_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_ZERO    = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
    logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;
    logic             rsp_divzero_q, rsp_divzero_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic             grant_s;
    logic             xfer_s;
    logic             timeout_hit_s;
    logic [WIDTH-1:0] sel_dividend_s;
    logic [WIDTH-1:0] sel_divisor_s;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_s = 1'b0;
        if (bus.Req0_valid && bus.Req1_valid) begin
            grant_s = ~last_q;
        end else if (bus.Req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        sel_dividend_s = grant_s ? bus.Req1_dividend : bus.Req0_dividend;
        sel_divisor_s  = grant_s ? bus.Req1_divisor  : bus.Req0_divisor;
        xfer_s = (state_q == ST_IDLE) && bus.Div_done &&
                 (grant_s ? bus.Req1_valid : bus.Req0_valid);
    end

    // Ready is also gated by Div_done so nothing is accepted while the divider is still settling.
    assign bus.Req0_ready = (state_q == ST_IDLE) && bus.Div_done && !grant_s;
    assign bus.Req1_ready = (state_q == ST_IDLE) && bus.Div_done &&  grant_s;

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Watchdog counts cycles spent in either wait state of the current operation.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d == ST_ISSUE) begin
            wait_cnt_d = {CW{1'b0}};
        end else if ((state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // The current wait cycle is the TIMEOUT-th one.
    assign timeout_hit_s = (wait_cnt_q == CW'(TIMEOUT - 1));

    // Watchdog counter register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_cnt_q <= {CW{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Transaction sequencing and next values of every registered output.
    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        id_d            = id_q;
        div_start_d     = 1'b0;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        rsp_valid_d     = 1'b0;
        rsp_id_d        = rsp_id_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_divzero_d   = rsp_divzero_q;
        rsp_timeout_d   = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    last_d         = grant_s;
                    id_d           = grant_s;
                    div_dividend_d = sel_dividend_s;
                    div_divisor_d  = sel_divisor_s;
                    if (sel_divisor_s == {WIDTH{1'b0}}) begin
                        state_d = ST_ZERO;
                    end else begin
                        state_d     = ST_ISSUE;
                        div_start_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (timeout_hit_s) begin
                    state_d         = ST_RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_id_d        = id_q;
                    rsp_quotient_d  = {WIDTH{1'b0}};
                    rsp_remainder_d = {WIDTH{1'b0}};
                    rsp_divzero_d   = 1'b0;
                    rsp_timeout_d   = 1'b1;
                end else if (!bus.Div_done) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (bus.Div_done) begin
                    state_d         = ST_RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_id_d        = id_q;
                    rsp_quotient_d  = bus.Div_quotient;
                    rsp_remainder_d = bus.Div_remainder;
                    rsp_divzero_d   = 1'b0;
                    rsp_timeout_d   = 1'b0;
                end else if (timeout_hit_s) begin
                    state_d         = ST_RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_id_d        = id_q;
                    rsp_quotient_d  = {WIDTH{1'b0}};
                    rsp_remainder_d = {WIDTH{1'b0}};
                    rsp_divzero_d   = 1'b0;
                    rsp_timeout_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_ZERO: begin
                state_d         = ST_RESP;
                rsp_valid_d     = 1'b1;
                rsp_id_d        = id_q;
                rsp_quotient_d  = {WIDTH{1'b1}};
                rsp_remainder_d = div_dividend_q;
                rsp_divzero_d   = 1'b1;
                rsp_timeout_d   = 1'b0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation without a response.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q         <= ST_IDLE;
            last_q          <= 1'b1;
            id_q            <= 1'b0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= {WIDTH{1'b0}};
            div_divisor_q   <= {WIDTH{1'b0}};
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_quotient_q  <= {WIDTH{1'b0}};
            rsp_remainder_q <= {WIDTH{1'b0}};
            rsp_divzero_q   <= 1'b0;
            rsp_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            id_q            <= id_d;
            div_start_q     <= div_start_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_divzero_q   <= rsp_divzero_d;
            rsp_timeout_q   <= rsp_timeout_d;
        end
    end

    assign bus.Div_start     = div_start_q;
    assign bus.Div_dividend  = div_dividend_q;
    assign bus.Div_divisor   = div_divisor_q;
    assign bus.Rsp_valid     = rsp_valid_q;
    assign bus.Rsp_id        = rsp_id_q;
    assign bus.Rsp_quotient  = rsp_quotient_q;
    assign bus.Rsp_remainder = rsp_remainder_q;
    assign bus.Rsp_divzero   = rsp_divzero_q;
    assign bus.Rsp_timeout   = rsp_timeout_q;
endmodule
